// File: rtl/game_tick_scheduler_if.sv
// rtl/game_tick_scheduler_if.sv - update request/acknowledge handshake between scheduler and update engine
interface game_tick_scheduler_if;
    logic upd_req;
    logic upd_obj;
    logic upd_ack;

    modport master (
        output upd_req,
        output upd_obj,
        input  upd_ack
    );

    modport slave (
        input  upd_req,
        input  upd_obj,
        output upd_ack
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - frame strobe, paddle/ball update periods, speed level and update handshake
module game_tick_scheduler #(
    parameter int FRAME_DIV     = 833333,
    parameter int CW            = 20,
    parameter int PADDLE_PERIOD = 4,
    parameter int BALL_BASE     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          hit,
    input  logic                          miss,
    game_tick_scheduler_if.master         upd,
    output logic                          frame_tick,
    output logic [1:0]                    speed_level,
    output logic                          busy,
    output logic                          overrun
);
    localparam int PW = (PADDLE_PERIOD > 1) ? $clog2(PADDLE_PERIOD) : 1;
    localparam int BW = (BALL_BASE > 1) ? $clog2(BALL_BASE) : 1;

    localparam logic [CW-1:0] FRAME_RELOAD  = CW'(FRAME_DIV - 1);
    localparam logic [PW-1:0] PADDLE_RELOAD = PW'(PADDLE_PERIOD - 1);
    localparam logic [BW-1:0] BALL_INIT     = BW'(BALL_BASE - 1);

    typedef enum logic [1:0] {IDLE, REQ_P, REQ_B} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   fcnt;
    logic [PW-1:0]   pcnt;
    logic [BW-1:0]   bcnt;
    logic [BW-1:0]   ball_reload;
    int              ball_room;
    logic            pend_p, pend_b;
    logic            fs_next, p_due, b_due, p_clr, b_clr;

    assign fs_next = enable && (fcnt == '0);
    assign p_due   = fs_next && (pcnt == '0);
    assign b_due   = fs_next && (bcnt == '0);
    assign p_clr   = (state == REQ_P) && upd.upd_ack;
    assign b_clr   = (state == REQ_B) && upd.upd_ack;
    assign busy    = (state != IDLE);

    // Faster levels shorten the ball period, but never below one frame.
    always_comb begin
        ball_room = BALL_BASE - int'(speed_level);
        if (ball_room < 1) begin
            ball_room = 1;
        end
        ball_reload = BW'(ball_room - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt        <= FRAME_RELOAD;
            frame_tick  <= 1'b0;
            pcnt        <= PADDLE_RELOAD;
            bcnt        <= BALL_INIT;
            pend_p      <= 1'b0;
            pend_b      <= 1'b0;
            overrun     <= 1'b0;
            speed_level <= 2'd0;
        end else begin
            if (enable) begin
                frame_tick <= fs_next;
                fcnt       <= fs_next ? FRAME_RELOAD : fcnt - CW'(1);
            end
            if (fs_next) begin
                pcnt <= (pcnt == '0) ? PADDLE_RELOAD : pcnt - PW'(1);
                bcnt <= (bcnt == '0) ? ball_reload : bcnt - BW'(1);
            end
            // A due event landing on its own ack re-arms the request instead of being lost.
            pend_p <= p_due || (pend_p && !p_clr);
            pend_b <= b_due || (pend_b && !b_clr);
            if ((p_due && pend_p && !p_clr) || (b_due && pend_b && !b_clr)) begin
                overrun <= 1'b1;
            end
            if (miss) begin
                speed_level <= 2'd0;
            end else if (hit && speed_level != 2'd3) begin
                speed_level <= speed_level + 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        upd.upd_req = 1'b0;
        upd.upd_obj = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_p) begin
                    state_next = REQ_P;
                end else if (pend_b) begin
                    state_next = REQ_B;
                end
            end
            REQ_P: begin
                upd.upd_req = 1'b1;
                if (upd.upd_ack) begin
                    state_next = IDLE;
                end
            end
            REQ_B: begin
                upd.upd_req = 1'b1;
                upd.upd_obj = 1'b1;
                if (upd.upd_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - directed vector bench for game_tick_scheduler
module tb_game_tick_scheduler;
    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       hit;
    logic       miss;
    logic       frame_tick;
    logic [1:0] speed_level;
    logic       busy;
    logic       overrun;

    int n_vec = 0;
    int n_bad = 0;

    game_tick_scheduler_if u_if ();

    game_tick_scheduler #(
        .FRAME_DIV     (4),
        .CW            (3),
        .PADDLE_PERIOD (2),
        .BALL_BASE     (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .hit         (hit),
        .miss        (miss),
        .upd         (u_if),
        .frame_tick  (frame_tick),
        .speed_level (speed_level),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst, en, hit, miss, ack;
        logic       ft, req, obj;
        logic [1:0] sl;
        logic       busy, ov;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, en, h, m, a, ft, rq, ob, input logic [1:0] sl, input logic bz, ov);
        vec_t v;
        v.rst = rst; v.en = en; v.hit = h; v.miss = m; v.ack = a;
        v.ft = ft; v.req = rq; v.obj = ob; v.sl = sl; v.busy = bz; v.ov = ov;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; hit = 1'b0; miss = 1'b0; u_if.upd_ack = 1'b0;

        //  rst en hit miss ack | ft req obj sl busy ov
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // E1
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);   // E4 frame 1
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);   // E8 frame 2, paddle due
        add(0, 1, 0, 0, 0,  0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0);   // ack while idle
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);   // E12 frame 3, ball due
        add(0, 1, 1, 0, 0,  0, 1, 1, 1, 1, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);   // E16 frame 4, paddle due
        add(0, 1, 0, 0, 0,  0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);   // E20 frame 5, nothing due
        add(0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);   // E24 frame 6, both due
        add(0, 1, 0, 0, 0,  0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,  0, 1, 1, 1, 1, 0);
        add(0, 1, 0, 0, 1,  1, 0, 0, 1, 0, 0);   // E28 frame 7

        @(negedge clock);
        foreach (tbl[i]) begin
            reset = tbl[i].rst; enable = tbl[i].en; hit = tbl[i].hit;
            miss = tbl[i].miss; u_if.upd_ack = tbl[i].ack;
            tick();
            chk($sformatf("v%0d frame_tick", i), int'(frame_tick), int'(tbl[i].ft));
            chk($sformatf("v%0d upd_req", i), int'(u_if.upd_req), int'(tbl[i].req));
            chk($sformatf("v%0d upd_obj", i), int'(u_if.upd_obj), int'(tbl[i].obj));
            chk($sformatf("v%0d speed_level", i), int'(speed_level), int'(tbl[i].sl));
            chk($sformatf("v%0d busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("v%0d overrun", i), int'(overrun), int'(tbl[i].ov));
        end
        hit = 1'b0; u_if.upd_ack = 1'b0;

        // Ack coinciding with due, then ball overrun while in REQ_B.
        miss = 1'b1; tick(); miss = 1'b0;                       // E29
        chk("miss clears speed", int'(speed_level), 0);
        run(3);                                                 // E32
        chk("frame 8 tick", int'(frame_tick), 1);
        tick();                                                 // E33
        chk("frame 8 paddle req", int'(u_if.upd_req), 1);
        chk("frame 8 paddle obj", int'(u_if.upd_obj), 0);
        run(6);                                                 // E39
        chk("req held without ack", int'(u_if.upd_req), 1);
        u_if.upd_ack = 1'b1; tick(); u_if.upd_ack = 1'b0;       // E40 ack + paddle due
        chk("coincide ack drops req", int'(u_if.upd_req), 0);
        chk("coincide no overrun", int'(overrun), 0);
        tick();                                                 // E41
        chk("coincide pend kept req", int'(u_if.upd_req), 1);
        chk("coincide pend kept obj", int'(u_if.upd_obj), 0);
        u_if.upd_ack = 1'b1; tick(); u_if.upd_ack = 1'b0;       // E42
        tick();                                                 // E43
        chk("ball after paddle obj", int'(u_if.upd_obj), 1);
        tick();                                                 // E44 ball due again
        chk("ball overrun set", int'(overrun), 1);
        u_if.upd_ack = 1'b1; tick(); u_if.upd_ack = 1'b0;       // E45
        chk("overrun sticky after ack", int'(overrun), 1);
        tick();                                                 // E46
        chk("single grant for backlog", int'(u_if.upd_req), 0);

        // Speed saturation and miss priority.
        for (int k = 1; k <= 4; k++) begin
            hit = 1'b1; tick(); hit = 1'b0;
            chk($sformatf("hit %0d speed", k), int'(speed_level), (k > 3) ? 3 : k);
        end
        hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
        chk("hit+miss speed", int'(speed_level), 0);

        // Reset clears sticky overrun; then a 10-cycle freeze mid-frame.
        reset = 1'b1; tick(); reset = 1'b0;
        chk("reset clears overrun", int'(overrun), 0);
        chk("reset clears req", int'(u_if.upd_req), 0);
        enable = 1'b1; run(2);
        enable = 1'b0; run(10);
        chk("no tick while frozen", int'(frame_tick), 0);
        enable = 1'b1;
        n = 12;
        do begin tick(); n++; end while (frame_tick == 1'b0 && n < 40);
        chk("freeze delays tick", n, 14);
        run(4);                                                 // e18 frame 2
        chk("post-freeze frame 2 tick", int'(frame_tick), 1);
        tick();                                                 // e19
        chk("post-freeze paddle req", int'(u_if.upd_req), 1);
        enable = 1'b0; tick();                                  // e20
        chk("req holds while frozen", int'(u_if.upd_req), 1);
        u_if.upd_ack = 1'b1; tick(); u_if.upd_ack = 1'b0;       // e21
        chk("ack completes while frozen", int'(busy), 0);
        enable = 1'b1;

        // Reset while REQ_B is outstanding and never acknowledged.
        run(3);                                                 // e24 ball due
        tick();                                                 // e25
        chk("REQ_B before reset obj", int'(u_if.upd_obj), 1);
        chk("REQ_B before reset busy", int'(busy), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("reset mid REQ_B req", int'(u_if.upd_req), 0);
        chk("reset mid REQ_B busy", int'(busy), 0);
        n = 0;
        do begin tick(); n++; end while (frame_tick == 1'b0 && n < 20);
        chk("first tick after reset", n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Frame-rate and update scheduler for the Pong game logic. Divides the system clock into a frame strobe, counts frames into separate paddle and ball update periods, and tracks a ball speed level that shortens the ball period. It hands each due update to the shared object-update/draw engine over a req/ack handshake, one object at a time, with paddles taking priority over the ball.

## Interface
- FRAME_DIV, 833333, clock cycles per frame (50 MHz / 60 Hz); must be ≥2
- CW, 20, frame counter width; must satisfy 2^CW > FRAME_DIV
- PADDLE_PERIOD, 4, frames between paddle updates; must be ≥1
- BALL_BASE, 4, frames between ball updates at speed level 0; must be ≥1

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  game running; low freezes all three counters
- hit  in  1  one-cycle pulse, ball struck a paddle
- miss  in  1  one-cycle pulse, ball left the field
- upd_ack  in  1  update engine finished the current object
- frame_tick  out  1  one-cycle frame strobe
- upd_req  out  1  update request, held high until acknowledged
- upd_obj  out  1  object being requested: 0 = paddles, 1 = ball
- speed_level  out  2  current ball speed level, 0..3
- busy  out  1  FSM is not in IDLE
- overrun  out  1  sticky: an update came due while the same object was still pending

## Operation
- Reset values: fcnt = FRAME_DIV-1, pcnt = PADDLE_PERIOD-1, bcnt = BALL_BASE-1, pend_p = pend_b = 0, state = IDLE.
- All outputs are 0 in reset.
- Frame counter: on each enabled edge, if fcnt==0 then fcnt reloads FRAME_DIV-1 and the internal strobe fs=1; otherwise fcnt decrements and fs=0.
- frame_tick is fs, registered.
- Paddle counter: updates only on fs. If pcnt==0, pcnt reloads PADDLE_PERIOD-1 and pend_p is set; otherwise pcnt decrements.
- Ball counter: same behaviour as the paddle counter and sets pend_b. Its reload value is max(BALL_BASE - speed_level, 1) - 1.
- A speed change only takes effect at the next ball reload.
- Speed level: hit increments speed_level, saturating at 3. miss clears it to 0. If hit and miss arrive together, miss wins.
- Speed updates happen regardless of enable.
- FSM states: IDLE, REQ_P, REQ_B.
  - IDLE: if pend_p, go to REQ_P; else if pend_b, go to REQ_B.
  - REQ_P: upd_req=1, upd_obj=0. On upd_ack, clear pend_p and return to IDLE.
  - REQ_B: upd_req=1, upd_obj=1. On upd_ack, clear pend_b and return to IDLE.
- upd_ack is ignored when upd_req is low.
- Due while pending: if an object comes due while its pend bit is set and is not being cleared this cycle, overrun is set (sticky until reset) and pend stays 1. Due events never queue.
- Due coinciding with ack: if an object comes due on the same edge its pend bit clears by ack, pend stays 1 and overrun is not set.
- enable low: counters and fs freeze. An in-progress handshake still completes, and pending requests are still granted.

## Timing
- Tick period: frame_tick pulses every FRAME_DIV enabled cycles.
- First tick: the first frame_tick is high after the FRAME_DIV-th enabled edge following reset release.
- pend_x rises on the same edge that frame_tick rises.
- upd_req rises one edge after pend_x is visible in IDLE.
- upd_req and busy fall on the edge that samples upd_ack=1.
- At least one IDLE cycle separates consecutive grants. When both objects are pending, the ball is granted 2 cycles after the paddle ack.
- Reset mid-handshake: upd_req, busy and overrun are 0 on the edge after reset is sampled high.
- hit/miss: speed_level changes one edge after the pulse is sampled.

## Test plan
- Frame strobe (FRAME_DIV=4, enable held high from reset release): frame_tick high after edges 4, 8, 12; one cycle wide each; never high during reset.
- Periods and priority (PADDLE_PERIOD=2, BALL_BASE=2, ack asserted 1 cycle after each req): both objects come due at frame 2; paddle req (obj=0) is granted first, ball req (obj=1) is granted 2 cycles after the paddle ack; both recur every 2 frames.
- Speed (BALL_BASE=3): three hit pulses give speed_level 1, 2, 3, and a 4th hit stays at 3. The ball period shrinks from 3 frames to 2, then 1 (floor). hit and miss in the same cycle give speed_level=0.
- Overrun (PADDLE_PERIOD=1, ack withheld for 2 frames): overrun=1 at the second frame_tick and stays high after the eventual ack. Only one paddle grant is issued for the backlog.
- Freeze: with enable dropped mid-frame for 10 cycles, frame_tick is delayed by exactly 10 cycles, and an outstanding req still completes on ack.
- Reset during REQ_B with the ack never given: upd_req=0 and busy=0 on the edge after reset; first frame_tick after release arrives FRAME_DIV edges later.
